// File: rtl/bramctrl_arb_if.sv
// Requester-side bus of the multi-channel BRAM arbiter: per-channel request fields
// packed by channel, plus the shared tagged read-return and init status.
interface bramctrl_arb_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 1
) ();
    logic [NUM_CH-1:0]            ch_req;
    logic [NUM_CH-1:0]            ch_we;
    logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata;
    logic [NUM_CH-1:0]            ch_ack;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic                         rd_valid;
    logic [CH_W-1:0]              rd_ch;
    logic                         init_done;

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata,
        input  ch_ack, rd_data, rd_valid, rd_ch, init_done
    );

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata,
        output ch_ack, rd_data, rd_valid, rd_ch, init_done
    );
endinterface

// File: rtl/bramctrl_arb.sv
// Round-robin arbiter of NUM_CH requesters onto one single-port RAM with a
// 1-cycle registered read; the RAM is zero-filled after every reset.
module bramctrl_arb #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    bramctrl_arb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;
    logic [CH_W-1:0]       rr_q, rr_d;

    logic                  gnt_found;
    logic [CH_W-1:0]       gnt_idx;
    logic [NUM_CH-1:0]     gnt_onehot;
    logic                  gnt_we;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;

    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [CH_W-1:0]       rd_ch_q;

    // Two passes give the wrap-around search: channels at or above the
    // pointer first, then the ones below it.
    always_comb begin
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        gnt_we     = 1'b0;
        gnt_addr   = '0;
        gnt_wdata  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!gnt_found && bus.ch_req[c] && (c >= int'(rr_q))) begin
                gnt_found     = 1'b1;
                gnt_idx       = CH_W'(c);
                gnt_onehot[c] = 1'b1;
                gnt_we        = bus.ch_we[c];
                gnt_addr      = bus.ch_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_wdata     = bus.ch_wdata[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!gnt_found && bus.ch_req[c] && (c < int'(rr_q))) begin
                gnt_found     = 1'b1;
                gnt_idx       = CH_W'(c);
                gnt_onehot[c] = 1'b1;
                gnt_we        = bus.ch_we[c];
                gnt_addr      = bus.ch_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_wdata     = bus.ch_wdata[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        rr_d        = rr_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        case (state_q)
            ST_INIT: begin
                ram_we     = 1'b1;
                ram_addr   = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (gnt_found) begin
                    ram_we    = gnt_we;
                    ram_re    = !gnt_we;
                    ram_addr  = gnt_addr;
                    ram_wdata = gnt_wdata;
                    if (gnt_idx == CH_W'(NUM_CH - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = gnt_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rr_q        <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            rr_q        <= rr_d;
        end
    end

    // RAM array carries no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
        end else begin
            rd_valid_q <= ram_re;
            if (ram_re) begin
                rd_data_q <= mem[ram_addr];
                rd_ch_q   <= gnt_idx;
            end
        end
    end

    assign bus.ch_ack    = (state_q == ST_RUN) ? gnt_onehot : '0;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_ch     = rd_ch_q;
    assign bus.init_done = init_done_q;

endmodule
